// File: rtl/mem_wb_pipe_pkg.sv
// MEM->WB pipeline register: shared payload layout and state encodings.
// Field offsets are XLEN-dependent, so they are exposed as constant functions.
package mem_wb_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WB_SEL_VALE = 2'd0,
    WB_SEL_VALM = 2'd1,
    WB_SEL_PC4  = 2'd2,
    WB_SEL_RSV  = 2'd3
  } wb_sel_e;

  localparam int OFF_WEN  = 0;
  localparam int OFF_RD   = 1;
  localparam int RD_W     = 5;
  localparam int OFF_SEL  = 6;
  localparam int SEL_W    = 2;
  localparam int OFF_VALE = 8;
  localparam int INSTR_W  = 32;

  function automatic int off_valm(input int xlen);
    return OFF_VALE + xlen;
  endfunction

  function automatic int off_commit(input int xlen);
    return OFF_VALE + 2 * xlen;
  endfunction

  function automatic int off_pc(input int xlen);
    return off_commit(xlen) + 1;
  endfunction

  function automatic int off_instr(input int xlen);
    return off_pc(xlen) + xlen;
  endfunction

  function automatic int off_pre_pc(input int xlen);
    return off_instr(xlen) + INSTR_W;
  endfunction

  function automatic int pld_w(input int xlen);
    return off_pre_pc(xlen) + xlen;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_skid.sv
// Single-entry holding register with valid/ready on both sides.
// clr drops the held entry; data is only loaded when the slot is free.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (in_valid && !valid_q) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB stage register with optional 2-entry skid, qualified WB/commit
// strobes and a retired-instruction counter.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter  int XLEN    = 64,
  parameter  bit SKID_EN = 1'b1,
  localparam int PLD_W   = pld_w(XLEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PLD_W-1:0] in_pld,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PLD_W-1:0] out_pld,
  output logic             out_wb_reg_wen,
  output logic             out_commit,
  output logic [XLEN-1:0]  retired_cnt
);

  localparam int OFF_COMMIT = off_commit(XLEN);

  state_e            state_q, state_d;
  logic [PLD_W-1:0]  main_q, main_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [XLEN-1:0]   cnt_q;

  logic              accept, drain;
  logic              skid_wr, skid_rd;
  logic              skid_valid, skid_free;
  logic [PLD_W-1:0]  skid_data;

  assign drain  = out_valid_q && out_ready;
  assign accept = in_valid && in_ready && !flush;

  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = in_ready_q;
      skid_buf #(.W(PLD_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .in_valid  (skid_wr),
        .in_ready  (skid_free),
        .in_data   (in_pld),
        .out_valid (skid_valid),
        .out_ready (skid_rd),
        .out_data  (skid_data)
      );
    end else begin : g_noskid
      assign in_ready   = !out_valid_q || out_ready;
      assign skid_valid = 1'b0;
      assign skid_free  = 1'b0;
      assign skid_data  = '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_wr = 1'b0;
    skid_rd = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          main_d  = in_pld;
        end
      end
      ST_FULL: begin
        if (accept && drain) begin
          main_d = in_pld;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end else if (accept && skid_free) begin
          state_d = ST_SKID;
          skid_wr = 1'b1;
        end
      end
      ST_SKID: begin
        if (drain && skid_valid) begin
          state_d = ST_FULL;
          main_d  = skid_data;
          skid_rd = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush wins over every transition; payload contents are left as-is
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= (state_d != ST_EMPTY);
      in_ready_q  <= (state_d != ST_SKID);
      if (drain && main_q[OFF_COMMIT]) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pld        = main_q;
  assign retired_cnt    = cnt_q;
  assign out_commit     = out_valid_q && main_q[OFF_COMMIT];
  assign out_wb_reg_wen = out_valid_q && main_q[OFF_WEN]
                       && (main_q[OFF_RD +: RD_W] != '0);

endmodule
